// File: rtl/intr_pulse_capture.sv
// intr_pulse_capture
// Receiving end of the interrupt pulse path. Rising edges on pulse_in set sticky
// pending bits, raise per-source overflow flags when a source fires again before
// software cleared it, and bump saturating per-source event counters. A masked OR
// of the pending bits drives a registered level interrupt. Software reaches the
// state through a four-phase req/ack register port.

module intr_pulse_capture #(
  parameter int N_SRC = 4,   // number of pulse sources (1..16)
  parameter int CNT_W = 16   // width of each saturating event counter (1..32)
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic [N_SRC-1:0] pulse_in,
  input  logic             reg_req,
  input  logic             reg_wr,
  input  logic [4:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic             reg_ack,
  output logic [31:0]      reg_rdata,
  output logic             irq
);

  // Word addresses of the register map.
  localparam logic [4:0] ADDR_PENDING  = 5'h00;
  localparam logic [4:0] ADDR_MASK     = 5'h01;
  localparam logic [4:0] ADDR_OVERFLOW = 5'h02;

  // Count registers live at 0x10 + source index.
  localparam logic [4:0]       N_SRC_L  = 5'(N_SRC);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,    // waiting for reg_req
    ST_ACCESS,  // write performed / read data captured at the end of this cycle
    ST_ACK,     // reg_ack high for exactly this cycle
    ST_WAIT     // waiting for the master to drop reg_req
  } state_t;

  state_t state_q;
  state_t state_d;

  // Edge-detect history and the one-cycle event strobes derived from it.
  logic [N_SRC-1:0] pulse_q;
  logic [N_SRC-1:0] pulse_evt;

  // Software-visible state.
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] overflow;
  logic [CNT_W-1:0] cnt [N_SRC];

  // Access decode.
  logic             wr_en;
  logic             rd_en;
  logic [3:0]       cnt_idx;
  logic             cnt_hit;
  logic [N_SRC-1:0] w1c_pend;
  logic [N_SRC-1:0] w1c_ovf;
  logic [N_SRC-1:0] cnt_clr;
  logic             mask_we;
  logic [31:0]      rd_mux;

  // Write data above the source field carries no meaning for any register.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[31:N_SRC];

  // A source fires once per rising edge, however long its pulse is held.
  assign pulse_evt = pulse_in & ~pulse_q;

  // Handshake state register; reset aborts any access in flight without an ack.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all flops update from
      // pre-edge values, independent of statement order.
      state_q <= state_d;
    end
  end

  // Handshake next-state: one ack per request, then wait for req to fall.
  always_comb begin
    // NOTE: assigning the default first means every path drives state_d, so no
    // latch can be inferred when a case arm leaves it untouched.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (reg_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_ACK;
      ST_ACK:    state_d = ST_WAIT;
      ST_WAIT:   if (!reg_req) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Address decode and per-register write strobes for the ACCESS cycle.
  always_comb begin
    wr_en    = (state_q == ST_ACCESS) &&  reg_wr;
    rd_en    = (state_q == ST_ACCESS) && !reg_wr;
    cnt_idx  = reg_addr[3:0];
    cnt_hit  = reg_addr[4] && ({1'b0, cnt_idx} < N_SRC_L);
    mask_we  = wr_en && (reg_addr == ADDR_MASK);
    w1c_pend = (wr_en && (reg_addr == ADDR_PENDING))  ? reg_wdata[N_SRC-1:0] : '0;
    w1c_ovf  = (wr_en && (reg_addr == ADDR_OVERFLOW)) ? reg_wdata[N_SRC-1:0] : '0;
    cnt_clr  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (wr_en && cnt_hit && (cnt_idx == 4'(i))) cnt_clr[i] = 1'b1;
    end
  end

  // Read mux over the current (pre-event) register values; holes read zero.
  always_comb begin
    rd_mux = '0;
    if (reg_addr == ADDR_PENDING) begin
      rd_mux = 32'(pending);
    end else if (reg_addr == ADDR_MASK) begin
      rd_mux = 32'(mask);
    end else if (reg_addr == ADDR_OVERFLOW) begin
      rd_mux = 32'(overflow);
    end else if (cnt_hit) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cnt_idx == 4'(i)) rd_mux = 32'(cnt[i]);
      end
    end
  end

  // Sticky pending/overflow bits, mask register and edge-detect history.
  // A new event in the same cycle as a W1C of its bit wins, so nothing is lost.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pulse_q  <= '0;
      pending  <= '0;
      overflow <= '0;
      mask     <= '0;
    end else begin
      pulse_q  <= pulse_in;
      pending  <= (pending  & ~w1c_pend) | pulse_evt;
      overflow <= (overflow & ~w1c_ovf)  | (pulse_evt & pending);
      if (mask_we) mask <= reg_wdata[N_SRC-1:0];
    end
  end

  // Per-source saturating event counters; a clear coincident with an event
  // leaves the counter at one so that event is still accounted for.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      // NOTE: the counter array is software-visible right after reset, so every
      // element gets an explicit reset value rather than being left as storage.
      for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cnt_clr[i]) begin
          cnt[i] <= pulse_evt[i] ? CNT_ONE : '0;
        end else if (pulse_evt[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Registered outputs: ack in the cycle after ACCESS, read data captured with
  // it, and the level interrupt one cycle behind pending/mask.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      reg_ack <= (state_q == ST_ACCESS);
      if (rd_en) reg_rdata <= rd_mux;
      irq     <= |(pending & mask);
    end
  end

endmodule
